// File: rtl/tetris_pkg.sv
// Shared Tetris constants: clear-controller state codes, board geometry defaults,
// the main FSM's "no row" code and the line-clear points table.
package tetris_pkg;

  localparam int ROWS_DEF = 11;
  localparam int COLS_DEF = 8;

  localparam logic [3:0] NO_ROW = 4'(ROWS_DEF);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_FILL  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  // Classic scoring curve: more lines in one pass earn disproportionately more.
  function automatic logic [3:0] points(input logic [7:0] n);
    case (n)
      8'd0:    points = 4'd0;
      8'd1:    points = 4'd1;
      8'd2:    points = 4'd3;
      8'd3:    points = 4'd5;
      default: points = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/line_score_acc.sv
// Saturating score accumulator; adds points(lines_i) on the cycle add_en_i is high,
// result visible the following cycle. Cleared only by restart.
module line_score_acc
  import tetris_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clka,
  input  logic          restart,
  input  logic          add_en_i,
  input  logic [AW-1:0] lines_i,
  output logic [15:0]   score_o
);

  logic [15:0] score_q, score_d;
  logic [16:0] sum;

  always_comb begin
    sum     = {1'b0, score_q} + {13'b0, points(8'(lines_i))};
    score_d = score_q;
    if (add_en_i) begin
      score_d = sum[16] ? 16'hFFFF : sum[15:0];
    end
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score_o = score_q;

endmodule

// File: rtl/line_clear_ctrl.sv
// Board line-clear sequencer: scan rows bottom-up, drop full rows, compact, zero-fill top.
// Pass takes 2*ROWS+k+1 cycles (k = rows removed); no backpressure. LINE_SCORE_EN adds score.
module line_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int AW   = 4
) (
  input  logic            clka,
  input  logic            restart,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   lines_cleared,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  input  logic [COLS-1:0] rd_data,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [COLS-1:0] wr_data
`ifdef LINE_SCORE_EN
  ,
  output logic [15:0]     score
`endif
);

  localparam logic [AW-1:0] LAST = AW'(ROWS - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] count_q, count_d;
  logic [AW-1:0] lines_q;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    rd_en    = 1'b0;
    rd_addr  = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          count_d  = '0;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        rd_en   = 1'b1;
        rd_addr = rd_ptr_q;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        rd_ptr_d = rd_ptr_q + ONE;
        if (&rd_data) begin
          count_d = count_q + ONE;
        end else begin
          // A surviving row already in place needs no rewrite.
          if (wr_ptr_q != rd_ptr_q) begin
            wr_en   = 1'b1;
            wr_addr = wr_ptr_q;
            wr_data = rd_data;
          end
          wr_ptr_d = wr_ptr_q + ONE;
        end
        if (rd_ptr_q == LAST) begin
          state_d = (count_d == '0) ? S_FIN : S_FILL;
        end else begin
          state_d = S_READ;
        end
      end
      S_FILL: begin
        wr_en    = 1'b1;
        wr_addr  = wr_ptr_q;
        wr_ptr_d = wr_ptr_q + ONE;
        if (wr_ptr_q == LAST) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      lines_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      // Loaded on entry to FIN so the result is valid alongside done.
      if (state_d == S_FIN) begin
        lines_q <= count_d;
      end
    end
  end

  assign busy          = (state_q == S_READ) || (state_q == S_CHECK) || (state_q == S_FILL);
  assign lines_cleared = lines_q;

`ifdef LINE_SCORE_EN
  line_score_acc #(.AW(AW)) u_score (
    .clka     (clka),
    .restart  (restart),
    .add_en_i (done),
    .lines_i  (count_q),
    .score_o  (score)
  );
`endif

endmodule
